gpio_avmm_master: RTL and testbench
===================================

# gpio_avmm_master

Avalon-MM initiator that turns a simple command stream into single read/write transactions against a memory-mapped GPIO register slave. It drives direction and output registers and reads back sampled input registers on the slave's bus. It sits between a control source (test sequencer or soft CPU bridge) and the GPIO controller. One transaction is outstanding at a time.

## Interface
- REG_WIDTH, 32, width of data on command, response and Avalon-MM buses
- ADDR_WIDTH, 5, width of slave register address
- READ_LATENCY, 1, fixed slave read latency in cycles; legal range ≥1
- TIMEOUT_CYCLES, 255, maximum cycles a request may stall on waitrequest; used only with the timeout feature

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target register address
- cmd_wdata  in  REG_WIDTH  write data; ignored for reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_rdata  out  REG_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  transaction timed out
- avm_address  out  ADDR_WIDTH  Avalon-MM address
- avm_write  out  1  Avalon-MM write strobe
- avm_read  out  1  Avalon-MM read strobe
- avm_writedata  out  REG_WIDTH  Avalon-MM write data
- avm_readdata  in  REG_WIDTH  Avalon-MM read data
- avm_waitrequest  in  1  slave stall; tie 0 for slaves without it

## Operation
- FSM states: IDLE, REQ, WAIT_RD, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch write/addr/wdata and go to REQ.
  - avm_read or avm_write is registered high next cycle, per cmd_write.
- REQ:
  - avm_address, avm_writedata and the strobe are held constant while avm_waitrequest=1.
  - When the slave accepts (strobe && !waitrequest), the strobe drops at the next edge.
  - Write → RESP with rsp_rdata=0, rsp_err=0.
  - Read → WAIT_RD with latency counter loaded to READ_LATENCY.
- WAIT_RD:
  - Counter decrements each cycle.
  - In the cycle the counter equals 1, avm_readdata is captured into rsp_rdata, then → RESP.
  - Counter width is $clog2(READ_LATENCY+1).
- RESP:
  - rsp_valid=1 and response fields stable until rsp_ready=1, then → IDLE.
  - cmd_ready=0 in every state except IDLE; a command cannot be accepted in the RESP handshake cycle.
- avm_read and avm_write are never high together, and are never high outside REQ.
- Reset values:
  - state IDLE
  - all avm_* outputs 0
  - rsp_valid 0, rsp_rdata 0, rsp_err 0
  - cmd_ready 1 from the first cycle after reset deasserts; cmd_ready 0 while rst=1
- Reset mid-operation: abandon the transaction, drop strobes at the next edge, emit no response.

## Timing
- Command accepted at the end of cycle N; strobe high in cycle N+1.
- Write, no stall: strobe high only in N+1; rsp_valid in N+2.
- Read, no stall, READ_LATENCY=L: read high in N+1, data captured at the end of N+1+L, rsp_valid in N+2+L. With L=1, rsp_valid is in N+3.
- Each cycle of waitrequest=1 adds one cycle to all of the above.
- Back-to-back command throughput: one per (transaction latency + 1) cycles.

## Configuration
- GPIO_AVMM_MASTER_TIMEOUT_EN defined:
  - A stall counter runs in REQ.
  - If waitrequest is still 1 in the TIMEOUT_CYCLES-th strobe cycle, the strobe drops at the next edge and the block goes to RESP with rsp_err=1, rsp_rdata=0.
  - If waitrequest falls in that same cycle, the acceptance takes priority and there is no error.
- Not defined: no counter is built, rsp_err is tied 0, TIMEOUT_CYCLES is ignored, and REQ waits indefinitely.

## Test plan
- Write addr 3, data 0x1, waitrequest=0 → avm_write=1 only in N+1 with avm_address=3, avm_writedata=0x1; rsp_valid in N+2, rsp_err=0, rsp_rdata=0.
- Read addr 18, L=1, slave returns 0x00000001 one cycle after read → avm_read=1 only in N+1; rsp_valid in N+3 with rsp_rdata=0x00000001.
- Read with waitrequest=1 for 4 cycles → avm_read and avm_address stable for 5 cycles; rsp_valid in N+7.
- TIMEOUT_EN, TIMEOUT_CYCLES=8, waitrequest stuck at 1 → avm_read high for exactly 8 cycles; rsp_valid with rsp_err=1, rsp_rdata=0.
- rsp_ready held 0 for 3 cycles with next cmd_valid=1 → rsp_valid and data held stable, cmd_ready=0; next command accepted the cycle after the rsp handshake.
- rst=1 during WAIT_RD → next cycle all avm_* outputs 0, rsp_valid=0; no response ever emitted for that read.

Source files
------------

// File: rtl/gpio_avmm_master.sv
// Purpose: Avalon-MM initiator turning a command stream into single GPIO register reads/writes.
// Latency: write rsp 2 cycles after cmd accept; read rsp 2+READ_LATENCY cycles; +1 per waitrequest cycle.
// Backpressure: one transaction outstanding; cmd_ready only in IDLE; response held until rsp_ready.
//
// Ports:
//   clk, rst                       - single clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata - command stream (accepted on valid && ready)
//   rsp_valid/ready/rdata/err      - response stream (consumed on valid && ready)
//   avm_*                          - Avalon-MM initiator port toward the GPIO slave
//
// Optional feature: define GPIO_AVMM_MASTER_TIMEOUT_EN to abort a request that stalls on
// waitrequest for TIMEOUT_CYCLES strobe cycles (response with rsp_err=1, rsp_rdata=0).
module gpio_avmm_master #(
  parameter int REG_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [REG_WIDTH-1:0]  cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [REG_WIDTH-1:0]  rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_write,
  output logic                  avm_read,
  output logic [REG_WIDTH-1:0]  avm_writedata,
  input  logic [REG_WIDTH-1:0]  avm_readdata,
  input  logic                  avm_waitrequest
);

  localparam int LAT_W = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, RESP} state_t;

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;

`ifdef GPIO_AVMM_MASTER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  // Counts strobe cycles already spent stalled; value k means this is strobe cycle k+1.
  logic [STALL_W-1:0] stall_cnt;
  logic               err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Gated by rst so the command port looks busy for the whole reset window.
  assign cmd_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      avm_address   <= '0;
      avm_write     <= 1'b0;
      avm_read      <= 1'b0;
      avm_writedata <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
`ifdef GPIO_AVMM_MASTER_TIMEOUT_EN
      stall_cnt     <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            avm_address   <= cmd_addr;
            avm_writedata <= cmd_wdata;
            avm_write     <= cmd_write;
            avm_read      <= !cmd_write;
            state         <= REQ;
`ifdef GPIO_AVMM_MASTER_TIMEOUT_EN
            stall_cnt     <= '0;
            err_q         <= 1'b0;
`endif
          end
        end

        REQ: begin
          // The held strobe itself records whether this is a write or a read.
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            avm_read  <= 1'b0;
            if (avm_write) begin
              rsp_rdata <= '0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              lat_cnt <= LAT_W'(READ_LATENCY);
              state   <= WAIT_RD;
            end
          end
`ifdef GPIO_AVMM_MASTER_TIMEOUT_EN
          // Acceptance above wins over a timeout landing in the same cycle.
          else if (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            avm_write <= 1'b0;
            avm_read  <= 1'b0;
            rsp_rdata <= '0;
            err_q     <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
`endif
        end

        WAIT_RD: begin
          // Slave data is valid in the cycle where the counter reads 1.
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LAT_W'(1)) begin
            rsp_rdata <= avm_readdata;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_avmm_master.sv
// Bench for gpio_avmm_master: the bench acts as command source, response sink and GPIO slave.
// Expected timing and data come from per-transaction cycle formulas and a reference register file.
module tb_gpio_avmm_master;

  localparam int L    = 2;
  localparam int TOUT = 8;
`ifdef GPIO_AVMM_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [4:0]  avm_address;
  logic        avm_write;
  logic        avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  gpio_avmm_master #(
    .REG_WIDTH(32), .ADDR_WIDTH(5), .READ_LATENCY(L), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [31:0] ref_mem   [32];
  logic [31:0] slave_mem [32];
  int          rdq_due   [$];
  logic [31:0] rdq_dat   [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to the middle of the next cycle, play the slave for that cycle.
  task automatic step(input bit wreq);
    @(negedge clk);
    cyc++;
    if (rdq_due.size() > 0 && rdq_due[0] == cyc) begin
      avm_readdata = rdq_dat.pop_front();
      void'(rdq_due.pop_front());
    end else begin
      avm_readdata = $urandom;
    end
    avm_waitrequest = wreq;
    chk("strobe_exclusive", {31'd0, avm_read & avm_write}, 32'd0);
    if (avm_read === 1'b1 && !wreq) begin
      rdq_due.push_back(cyc + L);
      rdq_dat.push_back(slave_mem[avm_address]);
    end
    if (avm_write === 1'b1 && !wreq) slave_mem[avm_address] = avm_writedata;
  endtask

  // One complete transaction; cycle n is the accept cycle, r the first response cycle.
  task automatic run_txn(input bit wr, input logic [4:0] addr, input logic [31:0] wd,
                         input int stalls, input int hold);
    int n, last, r;
    bit to;
    logic [31:0] exp_rd;
    step(1'($urandom_range(0, 1)));
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("idle_strobes", {30'd0, avm_read, avm_write}, 32'd0);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    rsp_ready = 1'($urandom_range(0, 1));
    n  = cyc;
    to = TO_EN && (stalls >= TOUT);
    if (to) begin
      last   = n + TOUT;
      r      = last + 1;
      exp_rd = 32'd0;
    end else begin
      last   = n + 1 + stalls;
      r      = last + 1 + (wr ? 0 : L);
      exp_rd = wr ? 32'd0 : ref_mem[addr];
    end
    for (int c = n + 1; c <= r + hold; c++) begin
      step((c <= last) ? (c <= n + stalls) : 1'($urandom_range(0, 1)));
      // Keep a competing command present; it must never be taken while busy.
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = 5'($urandom);
      cmd_wdata = $urandom;
      chk("avm_write", {31'd0, avm_write}, {31'd0, wr && (c <= last)});
      chk("avm_read", {31'd0, avm_read}, {31'd0, !wr && (c <= last)});
      if (c <= last) begin
        chk("avm_address", {27'd0, avm_address}, {27'd0, addr});
        if (wr) chk("avm_writedata", avm_writedata, wd);
      end
      chk("busy_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, c >= r});
      if (c >= r) begin
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, to});
      end
      rsp_ready = (c < r) ? 1'($urandom_range(0, 1)) : (c >= r + hold);
    end
    cmd_valid = 1'b0;
    if (wr && !to) ref_mem[addr] = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst             = 1'b1;
    cmd_valid       = 1'b0;
    cmd_write       = 1'b0;
    cmd_addr        = '0;
    cmd_wdata       = '0;
    rsp_ready       = 1'b0;
    avm_readdata    = '0;
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ref_mem[i]   = $urandom;
      slave_mem[i] = ref_mem[i];
    end
    ref_mem[18]   = 32'h0000_0001;
    slave_mem[18] = 32'h0000_0001;

    // Reset state.
    step(1'b0);
    step(1'b0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_strobes", {30'd0, avm_read, avm_write}, 32'd0);
    chk("rst_avm_address", {27'd0, avm_address}, 32'd0);
    chk("rst_avm_writedata", avm_writedata, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;

    // Directed transactions.
    run_txn(1'b1, 5'd3, 32'h0000_0001, 0, 0);   // simple write
    run_txn(1'b0, 5'd18, 32'd0, 0, 0);          // simple read
    run_txn(1'b0, 5'd3, 32'd0, 4, 0);           // read with 4 stall cycles
    run_txn(1'b0, 5'd18, 32'd0, TOUT - 1, 0);   // acceptance in last allowed strobe cycle
    run_txn(1'b0, 5'd9, 32'd0, TOUT + 4, 0);    // timeout (or long stall when disabled)
    run_txn(1'b1, 5'd9, 32'hA5A5_5A5A, TOUT + 1, 1);
    run_txn(1'b1, 5'd12, 32'hDEAD_BEEF, 2, 3);  // response held off 3 cycles
    run_txn(1'b0, 5'd12, 32'd0, 0, 3);

    // Reset while waiting for read data: no response may ever appear.
    step(1'b0);
    chk("pre_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 5'd7;
    rsp_ready = 1'b1;
    n0 = cyc;
    step(1'b0);
    cmd_valid = 1'b0;
    chk("midrst_read_strobe", {31'd0, avm_read}, 32'd1);
    step(1'b0);
    chk("midrst_in_wait", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b1;
    step(1'b0);
    chk("midrst_strobes", {30'd0, avm_read, avm_write}, 32'd0);
    chk("midrst_address", {27'd0, avm_address}, 32'd0);
    chk("midrst_writedata", avm_writedata, 32'd0);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("midrst_cycle", cyc, n0 + 3);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0);
      chk("postrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("postrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    end

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
              ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, TOUT + 3))
                                          : int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
